pwm_from_counter: RTL

//  Downstream consumer of the parameterised free-running counter (0..MAX_VALUE, wraps to 0).

---
 rtl/pwm_from_counter_if.sv | 28 ++
 rtl/pwm_from_counter.sv | 104 ++++++++++
 2 files changed

// File: rtl/pwm_from_counter_if.sv
// ============================================================================
// Module   : pwm_from_counter_if
// Purpose  : Duty-cycle valid/ready channel feeding pwm_from_counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pwm_from_counter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );
endinterface

`default_nettype wire

// File: rtl/pwm_from_counter.sv
// ============================================================================
// Module   : pwm_from_counter
// Purpose  : Registered PWM from an upstream wrap counter; duty is shadowed
//            and only takes effect at a counter wrap.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_from_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = 200,
    parameter int PCNT_W    = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [WIDTH-1:0]  cnt_in,
    pwm_from_counter_if.slave      duty_bus,
    output logic                   pwm_out,
    output logic                   period_start,
    output logic [PCNT_W-1:0]      period_cnt,
    output logic                   duty_applied
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Duty is held one bit wider so MAX_VALUE+1 (always high) is representable.
    localparam logic [WIDTH:0]   c_full_duty = (WIDTH+1)'(MAX_VALUE + 1);
    localparam logic [WIDTH-1:0] c_max_cnt   = WIDTH'(MAX_VALUE);

    state_t              state_q,        state_d;
    logic                pending_q,      pending_d;
    logic [WIDTH:0]      shadow_q,       shadow_d;
    logic [WIDTH:0]      active_duty_q,  active_duty_d;
    logic [WIDTH-1:0]    prev_cnt_q,     prev_cnt_d;
    logic                pwm_out_q,      pwm_out_d;
    logic                period_start_q, period_start_d;
    logic [PCNT_W-1:0]   period_cnt_q,   period_cnt_d;
    logic                duty_applied_q, duty_applied_d;

    logic                wrap;
    logic                accept;
    logic                apply;
    logic                run_next;
    logic [WIDTH:0]      duty_ext;
    logic [WIDTH:0]      duty_clamped;
    logic [WIDTH:0]      eff_duty;

    always_comb begin
        wrap         = (cnt_in == '0) && (prev_cnt_q == c_max_cnt);
        accept       = duty_bus.duty_valid && !pending_q;
        apply        = wrap && pending_q;
        run_next     = (state_q == ST_RUN) || apply;
        duty_ext     = {1'b0, duty_bus.duty_in};
        duty_clamped = (duty_ext > c_full_duty) ? c_full_duty : duty_ext;
        eff_duty     = apply ? shadow_q : active_duty_q;

        state_d        = run_next ? ST_RUN : ST_IDLE;
        prev_cnt_d     = cnt_in;
        shadow_d       = accept ? duty_clamped : shadow_q;
        active_duty_d  = apply ? shadow_q : active_duty_q;
        // Accept is impossible while pending, so accept and apply never collide.
        pending_d      = accept ? 1'b1 : (apply ? 1'b0 : pending_q);
        pwm_out_d      = run_next && ({1'b0, cnt_in} < eff_duty);
        period_start_d = wrap && run_next;
        period_cnt_d   = period_start_d ? (period_cnt_q + PCNT_W'(1)) : period_cnt_q;
        duty_applied_d = apply;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            pending_q      <= 1'b0;
            shadow_q       <= '0;
            active_duty_q  <= '0;
            prev_cnt_q     <= c_max_cnt;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            period_cnt_q   <= '0;
            duty_applied_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            shadow_q       <= shadow_d;
            active_duty_q  <= active_duty_d;
            prev_cnt_q     <= prev_cnt_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
            period_cnt_q   <= period_cnt_d;
            duty_applied_q <= duty_applied_d;
        end
    end

    assign duty_bus.duty_ready = !pending_q;
    assign pwm_out             = pwm_out_q;
    assign period_start        = period_start_q;
    assign period_cnt          = period_cnt_q;
    assign duty_applied        = duty_applied_q;

endmodule

`default_nettype wire
